seq_div_signed: RTL and testbench

//   Multi-cycle restoring divider: one shift-and-subtract step per clock, quotient and remainder out.

---
 rtl/seq_div_signed.sv | 184 ++++++++++++++++++
 tb/tb_seq_div_signed.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_signed.sv
// Multi-cycle restoring divider, signed or unsigned per operation.
// One shift-and-subtract step per clock; quotient, remainder and flags are registered.
module seq_div_signed #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic             neg
);

  // Handshake: start is accepted only while busy=0 (IDLE or DONE), which captures
  // sgn/A_in/B_in; done pulses for exactly one cycle when Q_out/R_out/flags are valid.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // Partial remainder before the shift is always below the divisor, so W bits
  // hold it; the shifted value needs W+1 bits but the difference fits back in W.
  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dsr_q});
    diff   = rem_sh[WIDTH-1:0] - dsr_q;
    q_fix  = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -dvd_q : dvd_q;
    r_fix  = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sgn_d   = sgn;
          a_d     = A_in;
          b_d     = B_in;
          dvd_d   = mag(A_in, sgn);
          dsr_d   = mag(B_in, sgn);
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          neg_d   = 1'b0;
          state_d = (B_in == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        if (fits) begin
          rem_d = diff;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        q_d     = q_fix;
        r_d     = r_fix;
        ovf_d   = sgn_q && (a_q == MOST_NEG) && (b_q == '1);
        neg_d   = sgn_q && q_fix[WIDTH-1];
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_ZERO: begin
        q_d     = '1;
        r_d     = a_q;
        dz_d    = 1'b1;
        neg_d   = sgn_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
    end
  end

  assign Q_out    = q_q;
  assign R_out    = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign overflow = ovf_q;
  assign neg      = neg_q;

endmodule

// File: tb/tb_seq_div_signed.sv
// Directed bench for seq_div_signed (WIDTH=8): latency, signed/unsigned results,
// overflow, divide by zero, ignored start, mid-op reset, back-to-back, model sweep.
module tb_seq_div_signed;

  logic       clk = 1'b0;
  logic       rst, start, sgn;
  logic [7:0] a_in, b_in;
  logic [7:0] q_out, r_out;
  logic       busy, done, div_zero, overflow, neg;

  int n_vec = 0;
  int n_err = 0;

  seq_div_signed #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A_in(a_in), .B_in(b_in),
    .Q_out(q_out), .R_out(r_out), .busy(busy), .done(done),
    .div_zero(div_zero), .overflow(overflow), .neg(neg)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle start; returns at the negedge just after the accepting edge.
  task automatic issue(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; sgn = s; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; 30 means it never came.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({q_out, r_out, busy, done, div_zero, overflow, neg} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {q_out, r_out, busy, done, div_zero, overflow, neg});
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [7:0]  ta[4] = '{8'd100, 8'd200, 8'd255, 8'd5};
    logic [7:0]  tb[4] = '{8'd7, 8'd15, 8'd1, 8'd9};
    logic [18:0] te[4] = '{{8'd14, 8'd2, 3'b000}, {8'd13, 8'd5, 3'b000},
                           {8'hFF, 8'h00, 3'b000}, {8'd0, 8'd5, 3'b000}};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ta[i], tb[i]);
      wait_done(cyc);
      n_vec++;
      if (cyc !== 9) begin
        n_err++;
        $display("FAIL unsigned_latency[%0d]: got %0d expected 9", i, cyc);
      end
      n_vec++;
      if ({q_out, r_out, div_zero, overflow, neg} !== te[i] || busy !== 1'b0) begin
        n_err++;
        $display("FAIL unsigned_result[%0d]: got %h busy %b expected %h busy 0",
                 i, {q_out, r_out, div_zero, overflow, neg}, busy, te[i]);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse[%0d]: got done %b busy %b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta[6] = '{8'hF9, 8'h07, 8'hF9, 8'hF8, 8'h80, 8'h7F};
    logic [7:0]  tb[6] = '{8'h02, 8'hFE, 8'hFE, 8'h04, 8'h01, 8'h80};
    logic [18:0] te[6] = '{{8'hFD, 8'hFF, 3'b001}, {8'hFD, 8'h01, 3'b001},
                           {8'h03, 8'hFF, 3'b000}, {8'hFE, 8'h00, 3'b001},
                           {8'h80, 8'h00, 3'b001}, {8'h00, 8'h7F, 3'b000}};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, ta[i], tb[i]);
      wait_done(cyc);
      n_vec++;
      if (cyc !== 9 || {q_out, r_out, div_zero, overflow, neg} !== te[i]) begin
        n_err++;
        $display("FAIL signed[%0d]: got %h after %0d cycles expected %h after 9",
                 i, {q_out, r_out, div_zero, overflow, neg}, cyc, te[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic        ts[2] = '{1'b1, 1'b0};
    logic [18:0] te[2] = '{{8'h80, 8'h00, 3'b011}, {8'h00, 8'h80, 3'b000}};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      issue(ts[i], 8'h80, 8'hFF);
      wait_done(cyc);
      n_vec++;
      if (cyc !== 9 || {q_out, r_out, div_zero, overflow, neg} !== te[i]) begin
        n_err++;
        $display("FAIL overflow[%0d]: got %h after %0d cycles expected %h after 9",
                 i, {q_out, r_out, div_zero, overflow, neg}, cyc, te[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic        ts[2] = '{1'b0, 1'b1};
    logic [7:0]  ta[2] = '{8'h5A, 8'h80};
    logic [18:0] te[2] = '{{8'hFF, 8'h5A, 3'b100}, {8'hFF, 8'h80, 3'b101}};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      issue(ts[i], ta[i], 8'h00);
      wait_done(cyc);
      n_vec++;
      if (cyc !== 1 || busy !== 1'b0 || {q_out, r_out, div_zero, overflow, neg} !== te[i]) begin
        n_err++;
        $display("FAIL div_zero[%0d]: got %h busy %b after %0d cycles expected %h busy 0 after 1",
                 i, {q_out, r_out, div_zero, overflow, neg}, busy, cyc, te[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    issue(1'b0, 8'd100, 8'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; sgn = 1'b1; a_in = 8'h11; b_in = 8'h03;
    @(negedge clk);
    start = 1'b0; a_in = 8'h00; b_in = 8'h00;
    wait_done(cyc);
    n_vec++;
    if (cyc !== 5 || {q_out, r_out, div_zero, overflow, neg} !== {8'd14, 8'd2, 3'b000}) begin
      n_err++;
      $display("FAIL ignore_start: got %h after %0d cycles expected %h after 5",
               {q_out, r_out, div_zero, overflow, neg}, cyc, {8'd14, 8'd2, 3'b000});
    end
  endtask

  task automatic test_midop_reset();
    int cyc;
    bit seen;
    issue(0, 8'd200, 8'd15);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({q_out, r_out, busy, done, div_zero, overflow, neg} !== 21'd0) begin
      n_err++;
      $display("FAIL midop_reset: got %h expected 0",
               {q_out, r_out, busy, done, div_zero, overflow, neg});
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got done seen %b expected 0", seen);
    end
    issue(1'b0, 8'd200, 8'd15);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 9 || {q_out, r_out, div_zero, overflow, neg} !== {8'd13, 8'd5, 3'b000}) begin
      n_err++;
      $display("FAIL after_reset: got %h after %0d cycles expected %h after 9",
               {q_out, r_out, div_zero, overflow, neg}, cyc, {8'd13, 8'd5, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; a_in = 8'd100; b_in = 8'd7;
    @(negedge clk);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 9 || {q_out, r_out} !== {8'd14, 8'd2}) begin
      n_err++;
      $display("FAIL b2b_first: got %h after %0d cycles expected %h after 9",
               {q_out, r_out}, cyc, {8'd14, 8'd2});
    end
    sgn = 1'b1; a_in = 8'hF9; b_in = 8'h02;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, done, div_zero, overflow, neg, q_out, r_out} !== {5'b10000, 8'd14, 8'd2}) begin
      n_err++;
      $display("FAIL b2b_accept: got %h expected %h",
               {busy, done, div_zero, overflow, neg, q_out, r_out}, {5'b10000, 8'd14, 8'd2});
    end
    wait_done(cyc);
    n_vec++;
    if (cyc !== 9 || {q_out, r_out, div_zero, overflow, neg} !== {8'hFD, 8'hFF, 3'b001}) begin
      n_err++;
      $display("FAIL b2b_second: got %h after %0d cycles expected %h after 9",
               {q_out, r_out, div_zero, overflow, neg}, cyc, {8'hFD, 8'hFF, 3'b001});
    end
  endtask

  task automatic test_sweep();
    logic       s;
    logic [7:0] a, b, eq, er;
    logic       ez, eo, en;
    int ia, ib, iq, ir, cyc;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      b = (i % 8 == 7) ? 8'h00 : 8'($urandom_range(0, 255));
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      if (b == 8'h00) begin
        eq = 8'hFF; er = a; ez = 1'b1; eo = 1'b0; en = s;
      end else begin
        iq = ia / ib;
        ir = ia % ib;
        eq = iq[7:0]; er = ir[7:0]; ez = 1'b0;
        eo = s && (a == 8'h80) && (b == 8'hFF);
        en = s && eq[7];
      end
      issue(s, a, b);
      wait_done(cyc);
      n_vec++;
      if (cyc !== ((b == 8'h00) ? 1 : 9) ||
          {q_out, r_out, div_zero, overflow, neg} !== {eq, er, ez, eo, en}) begin
        n_err++;
        $display("FAIL sweep[%0d] s=%b a=%h b=%h: got %h after %0d cycles expected %h",
                 i, s, a, b, {q_out, r_out, div_zero, overflow, neg}, cyc, {eq, er, ez, eo, en});
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_midop_reset();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
